pw_trigger_gen: RTL

- Front-end trigger sequencer in the fe_clk domain, driven by the PW register block's trigger/capture settings.
- On a pattern-match pulse while armed, emits a programmable train of up to pNUM_TRIGGER_PULSES trigger pulses, each with its own delay and width.
- Independently emits a single-cycle capture-enable pulse after a programmable capture delay. That pulse is what the register block uses to clear arm.

---
 rtl/pw_trigger_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pw_trigger_gen.sv
// Front-end trigger sequencer: on an armed pattern match, emits a programmable trigger pulse train
// and a delayed single-cycle capture-enable pulse. Optional pulse counter under PW_TRIG_PULSE_COUNT_EN.
module pw_trigger_gen #(
   parameter int pNUM_TRIGGER_PULSES  = 8,
   parameter int pNUM_TRIGGER_WIDTH   = 4,
   parameter int pTRIG_CNT_WIDTH      = 24,
   parameter int pCAPTURE_DELAY_WIDTH = 18
) (
   input  logic                                           fe_clk,
   input  logic                                           reset_i,
   input  logic                                           I_arm,
   input  logic                                           I_match,
   input  logic                                           I_trigger_enable,
   input  logic [pNUM_TRIGGER_WIDTH-1:0]                  I_num_triggers,
   input  logic [pTRIG_CNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_delay,
   input  logic [pTRIG_CNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_width,
   input  logic [pCAPTURE_DELAY_WIDTH-1:0]                I_capture_delay,
   output logic                                           O_trigger,
   output logic                                           O_capture_enable_pulse,
   output logic                                           O_busy
`ifdef PW_TRIG_PULSE_COUNT_EN
   ,
   output logic [pNUM_TRIGGER_WIDTH-1:0]                  O_pulses_done
`endif
);

   localparam int IDX_W = (pNUM_TRIGGER_PULSES > 1) ? $clog2(pNUM_TRIGGER_PULSES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_PULSE
   } state_t;

   state_t                             state_q, state_d;
   logic [pTRIG_CNT_WIDTH-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]                   idx_q, idx_d, idx_inc, n_last;
   logic                               trig_d;
   logic [pCAPTURE_DELAY_WIDTH-1:0]    cap_cnt;
   logic                               cap_active;
   logic                               start;

   // Counter load values: pulse 0 loads the raw delay, later pulses load max(d,1)-1 so that
   // exactly Di low cycles separate consecutive pulses; widths load max(w,1)-1.
   logic [pTRIG_CNT_WIDTH-1:0] dly_ld [pNUM_TRIGGER_PULSES];
   logic [pTRIG_CNT_WIDTH-1:0] wid_ld [pNUM_TRIGGER_PULSES];

   for (genvar gi = 0; gi < pNUM_TRIGGER_PULSES; gi++) begin : g_cfg
      logic [pTRIG_CNT_WIDTH-1:0] d_raw, w_raw;
      assign d_raw = I_trigger_delay[gi*pTRIG_CNT_WIDTH +: pTRIG_CNT_WIDTH];
      assign w_raw = I_trigger_width[gi*pTRIG_CNT_WIDTH +: pTRIG_CNT_WIDTH];
      if (gi == 0) begin : g_first
         assign dly_ld[gi] = d_raw;
      end else begin : g_rest
         assign dly_ld[gi] = (d_raw == '0) ? '0 : d_raw - 1'b1;
      end
      assign wid_ld[gi] = (w_raw == '0) ? '0 : w_raw - 1'b1;
   end

   always_comb begin
      if (I_num_triggers == '0)
         n_last = '0;
      else if (32'(I_num_triggers) >= pNUM_TRIGGER_PULSES)
         n_last = IDX_W'(pNUM_TRIGGER_PULSES - 1);
      else
         n_last = IDX_W'(I_num_triggers - 1'b1);
   end

   assign start   = I_match & I_arm & ~O_busy;
   assign idx_inc = idx_q + 1'b1;
   assign O_busy  = (state_q != ST_IDLE) | cap_active | O_capture_enable_pulse;

   // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      trig_d  = O_trigger;
      case (state_q)
         ST_IDLE: begin
            if (start && I_trigger_enable) begin
               state_d = ST_DELAY;
               cnt_d   = dly_ld[0];
               idx_d   = '0;
            end
         end
         ST_DELAY: begin
            if (!I_trigger_enable) begin
               state_d = ST_IDLE;
               trig_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_PULSE;
               trig_d  = 1'b1;
               cnt_d   = wid_ld[idx_q];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_PULSE: begin
            if (!I_trigger_enable) begin
               state_d = ST_IDLE;
               trig_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               trig_d = 1'b0;
               if (idx_q == n_last) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DELAY;
                  idx_d   = idx_inc;
                  cnt_d   = dly_ld[idx_inc];
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         O_trigger <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         O_trigger <= trig_d;
      end
   end

   // Capture counter runs independently of the trigger FSM and ignores I_trigger_enable.
   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         cap_cnt                <= '0;
         cap_active             <= 1'b0;
         O_capture_enable_pulse <= 1'b0;
      end else begin
         O_capture_enable_pulse <= 1'b0;
         if (start) begin
            cap_active <= 1'b1;
            cap_cnt    <= I_capture_delay;
         end else if (cap_active) begin
            if (cap_cnt == '0) begin
               cap_active             <= 1'b0;
               O_capture_enable_pulse <= 1'b1;
            end else begin
               cap_cnt <= cap_cnt - 1'b1;
            end
         end
      end
   end

`ifdef PW_TRIG_PULSE_COUNT_EN
   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i)
         O_pulses_done <= '0;
      else if (start)
         O_pulses_done <= '0;
      else if (O_trigger && !trig_d)
         O_pulses_done <= O_pulses_done + 1'b1;
   end
`endif

endmodule
